// File: rtl/axis_frame_arbiter.sv
// Two-input frame-aware AXI-Stream arbiter with registered output.
// Grants are held for a whole frame; per-input TLAST counters for status.
module axis_frame_arbiter #(
    parameter int DW = 512
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            ARB_MODE,
    input  logic [DW-1:0]   S0_TDATA,
    input  logic [DW/8-1:0] S0_TKEEP,
    input  logic            S0_TLAST,
    input  logic            S0_TVALID,
    output logic            S0_TREADY,
    input  logic [DW-1:0]   S1_TDATA,
    input  logic [DW/8-1:0] S1_TKEEP,
    input  logic            S1_TLAST,
    input  logic            S1_TVALID,
    output logic            S1_TREADY,
    output logic [DW-1:0]   M_TDATA,
    output logic [DW/8-1:0] M_TKEEP,
    output logic            M_TLAST,
    output logic            M_TVALID,
    input  logic            M_TREADY,
    output logic [1:0]      GRANT,
    output logic [31:0]     FRAME_CNT0,
    output logic [31:0]     FRAME_CNT1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t      state, state_n;
    logic        last, last_n;
    logic        slot_free;
    logic        acc0, acc1;
    logic [31:0] cnt0, cnt1;

    // Output slot can take a new beat when empty or draining this cycle.
    always_comb begin
        slot_free = !M_TVALID || M_TREADY;
        S0_TREADY = (state == GNT0) && slot_free;
        S1_TREADY = (state == GNT1) && slot_free;
        acc0      = S0_TVALID && S0_TREADY;
        acc1      = S1_TVALID && S1_TREADY;
    end

    always_comb begin
        state_n = state;
        last_n  = last;
        unique case (state)
            IDLE: begin
                if (S0_TVALID && S1_TVALID) begin
                    if (ARB_MODE || last) begin
                        state_n = GNT0;
                        last_n  = 1'b0;
                    end else begin
                        state_n = GNT1;
                        last_n  = 1'b1;
                    end
                end else if (S0_TVALID) begin
                    state_n = GNT0;
                    last_n  = 1'b0;
                end else if (S1_TVALID) begin
                    state_n = GNT1;
                    last_n  = 1'b1;
                end
            end
            GNT0: if (acc0 && S0_TLAST) state_n = IDLE;
            GNT1: if (acc1 && S1_TLAST) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_n;
            last  <= last_n;
        end
    end

    // Data registers move only on an accepted beat; a held beat is frozen.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            M_TDATA  <= '0;
            M_TKEEP  <= '0;
            M_TLAST  <= 1'b0;
            M_TVALID <= 1'b0;
        end else if (acc0) begin
            M_TDATA  <= S0_TDATA;
            M_TKEEP  <= S0_TKEEP;
            M_TLAST  <= S0_TLAST;
            M_TVALID <= 1'b1;
        end else if (acc1) begin
            M_TDATA  <= S1_TDATA;
            M_TKEEP  <= S1_TKEEP;
            M_TLAST  <= S1_TLAST;
            M_TVALID <= 1'b1;
        end else if (slot_free) begin
            M_TVALID <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (acc0 && S0_TLAST) cnt0 <= cnt0 + 32'd1;
            if (acc1 && S1_TLAST) cnt1 <= cnt1 + 32'd1;
        end
    end

    assign GRANT      = {state == GNT1, state == GNT0};
    assign FRAME_CNT0 = cnt0;
    assign FRAME_CNT1 = cnt1;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Directed bench for axis_frame_arbiter: arbitration vector table
// plus hand-written frame, backpressure, stall/reset and wrap sequences.
module tb_axis_frame_arbiter;

    localparam int DW = 64;
    localparam int KW = DW / 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          ARB_MODE = 1'b0;
    logic [DW-1:0] S0_TDATA = '0, S1_TDATA = '0;
    logic [KW-1:0] S0_TKEEP = '0, S1_TKEEP = '0;
    logic          S0_TLAST = 1'b0, S1_TLAST = 1'b0;
    logic          S0_TVALID = 1'b0, S1_TVALID = 1'b0;
    logic          S0_TREADY, S1_TREADY;
    logic [DW-1:0] M_TDATA;
    logic [KW-1:0] M_TKEEP;
    logic          M_TLAST, M_TVALID;
    logic          M_TREADY = 1'b1;
    logic [1:0]    GRANT;
    logic [31:0]   FRAME_CNT0, FRAME_CNT1;

    axis_frame_arbiter #(.DW(DW)) dut (
        .clk(clk), .resetn(resetn), .ARB_MODE(ARB_MODE),
        .S0_TDATA(S0_TDATA), .S0_TKEEP(S0_TKEEP), .S0_TLAST(S0_TLAST),
        .S0_TVALID(S0_TVALID), .S0_TREADY(S0_TREADY),
        .S1_TDATA(S1_TDATA), .S1_TKEEP(S1_TKEEP), .S1_TLAST(S1_TLAST),
        .S1_TVALID(S1_TVALID), .S1_TREADY(S1_TREADY),
        .M_TDATA(M_TDATA), .M_TKEEP(M_TKEEP), .M_TLAST(M_TLAST),
        .M_TVALID(M_TVALID), .M_TREADY(M_TREADY),
        .GRANT(GRANT), .FRAME_CNT0(FRAME_CNT0), .FRAME_CNT1(FRAME_CNT1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    typedef struct {
        logic       mode;
        logic       v0;
        logic       v1;
        logic [1:0] g;
    } vec_t;

    beat_t q0[$], q1[$], rx[$], exq[$];
    beat_t hold_b;
    logic  en0 = 1'b1, en1 = 1'b1;
    logic  prev_hold = 1'b0;
    int    ntest = 0, nfail = 0, cyc = 0, nh = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        ntest++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic beat_t mk(int src, int fr, int bt, int n);
        beat_t b;
        b.d = {8'(src), 8'(fr), 8'(bt), 40'h5A_C3_3C_A5_0F};
        b.l = (bt == n - 1);
        b.k = b.l ? 8'h0F : (8'hFF ^ 8'(bt));
        return b;
    endfunction

    task automatic push(int src, int fr, int n);
        for (int b = 0; b < n; b++) begin
            if (src == 0) q0.push_back(mk(0, fr, b, n));
            else          q1.push_back(mk(1, fr, b, n));
        end
    endtask

    task automatic drive();
        S0_TVALID = en0 && (q0.size() != 0);
        S1_TVALID = en1 && (q1.size() != 0);
        if (q0.size() != 0) {S0_TDATA, S0_TKEEP, S0_TLAST} = q0[0];
        else {S0_TDATA, S0_TKEEP, S0_TLAST} = '0;
        if (q1.size() != 0) {S1_TDATA, S1_TKEEP, S1_TLAST} = q1[0];
        else {S1_TDATA, S1_TKEEP, S1_TLAST} = '0;
    endtask

    // One clock: sample at negedge, advance sources #1 after posedge.
    task automatic step();
        logic hs0, hs1;
        @(negedge clk);
        if (M_TVALID && M_TREADY)
            rx.push_back({M_TDATA, M_TKEEP, M_TLAST});
        if (M_TVALID && !M_TREADY) begin
            chk("hold_tready", {S0_TREADY, S1_TREADY}, 0);
            if (prev_hold)
                chk("hold_data", {M_TDATA, M_TKEEP, M_TLAST}, hold_b);
            hold_b = {M_TDATA, M_TKEEP, M_TLAST};
            prev_hold = 1'b1;
            nh++;
        end else begin
            prev_hold = 1'b0;
        end
        hs0 = S0_TVALID && S0_TREADY;
        hs1 = S1_TVALID && S1_TREADY;
        @(posedge clk);
        #1;
        cyc++;
        if (hs0) void'(q0.pop_front());
        if (hs1) void'(q1.pop_front());
        drive();
    endtask

    task automatic rst();
        resetn = 1'b0;
        q0.delete();
        q1.delete();
        en0 = 1'b1;
        en1 = 1'b1;
        drive();
        prev_hold = 1'b0;
        step();
        resetn = 1'b1;
        rx.delete();
        exq.delete();
    endtask

    task automatic run_until(int n, int lim);
        int k;
        k = 0;
        while (rx.size() < n && k < lim) begin
            step();
            k++;
        end
        if (rx.size() < n) chk("timeout_rx", rx.size(), n);
    endtask

    task automatic chk_rx(string nm);
        chk({nm, "_n"}, rx.size(), exq.size());
        for (int i = 0; i < exq.size() && i < rx.size(); i++)
            chk(nm, rx[i], exq[i]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[10];
        int   e0, e1, vc, gc, mc, rn;
        vt[0] = '{1'b0, 1'b1, 1'b1, 2'b01};
        vt[1] = '{1'b0, 1'b1, 1'b1, 2'b10};
        vt[2] = '{1'b0, 1'b1, 1'b1, 2'b01};
        vt[3] = '{1'b1, 1'b1, 1'b1, 2'b01};
        vt[4] = '{1'b0, 1'b0, 1'b0, 2'b00};
        vt[5] = '{1'b0, 1'b1, 1'b1, 2'b10};
        vt[6] = '{1'b0, 1'b1, 1'b0, 2'b01};
        vt[7] = '{1'b0, 1'b0, 1'b1, 2'b10};
        vt[8] = '{1'b1, 1'b0, 1'b1, 2'b10};
        vt[9] = '{1'b0, 1'b1, 1'b1, 2'b01};

        // reset values, with both sources offering a beat
        push(0, 0, 1);
        push(1, 0, 1);
        drive();
        #12;
        chk("rst_grant", GRANT, 0);
        chk("rst_mvalid", M_TVALID, 0);
        chk("rst_mbeat", {M_TDATA, M_TKEEP, M_TLAST}, 0);
        chk("rst_tready", {S0_TREADY, S1_TREADY}, 0);
        chk("rst_cnt", {FRAME_CNT0, FRAME_CNT1}, 0);
        rst();

        // arbitration vectors with single-beat frames
        e0 = 0;
        e1 = 0;
        for (int i = 0; i < 10; i++) begin
            ARB_MODE = vt[i].mode;
            q0.delete();
            q1.delete();
            if (vt[i].v0) push(0, i, 1);
            if (vt[i].v1) push(1, i, 1);
            drive();
            step();
            chk($sformatf("vec%0d_grant", i), GRANT, vt[i].g);
            if (vt[i].g == 2'b00) continue;
            if (vt[i].g[0]) q1.delete();
            else q0.delete();
            drive();
            rn = rx.size();
            step();
            step();
            chk($sformatf("vec%0d_rxn", i), rx.size(), rn + 1);
            if (rx.size() > rn)
                chk($sformatf("vec%0d_beat", i), rx[rn],
                    mk(vt[i].g[0] ? 0 : 1, i, 0, 1));
            if (vt[i].g[0]) e0++;
            else e1++;
            chk($sformatf("vec%0d_cnt", i), {FRAME_CNT0, FRAME_CNT1},
                {32'(e0), 32'(e1)});
        end

        // single source 4-beat frame and latency
        rst();
        ARB_MODE = 1'b0;
        M_TREADY = 1'b1;
        push(0, 0, 4);
        drive();
        vc = cyc;
        gc = -1;
        mc = -1;
        for (int k = 0; k < 30 && rx.size() < 4; k++) begin
            step();
            if (GRANT == 2'b01 && gc < 0) gc = cyc;
            if (M_TVALID && mc < 0) mc = cyc;
        end
        chk("single_grant_lat", gc, vc + 1);
        chk("single_m_lat", mc, vc + 2);
        for (int b = 0; b < 4; b++) exq.push_back(mk(0, 0, b, 4));
        chk_rx("single_rx");
        chk("single_cnt0", FRAME_CNT0, 1);
        chk("single_grant_end", GRANT, 0);

        // round-robin contention with 3-beat frames
        rst();
        ARB_MODE = 1'b0;
        push(0, 0, 3);
        push(0, 1, 3);
        push(1, 0, 3);
        push(1, 1, 3);
        drive();
        run_until(12, 80);
        for (int f = 0; f < 2; f++)
            for (int s = 0; s < 2; s++)
                for (int b = 0; b < 3; b++) exq.push_back(mk(s, f, b, 3));
        chk_rx("rr_rx");
        chk("rr_cnt", {FRAME_CNT0, FRAME_CNT1}, {32'd2, 32'd2});

        // fixed priority: S1 starves while S0 keeps offering
        rst();
        ARB_MODE = 1'b1;
        for (int f = 0; f < 3; f++) begin
            push(0, f, 3);
            push(1, f, 3);
        end
        drive();
        run_until(9, 80);
        for (int f = 0; f < 3; f++)
            for (int b = 0; b < 3; b++) exq.push_back(mk(0, f, b, 3));
        chk_rx("fp_rx");
        chk("fp_cnt1", FRAME_CNT1, 0);

        // backpressure during a 5-beat S1 frame
        rst();
        ARB_MODE = 1'b0;
        push(1, 0, 5);
        drive();
        nh = 0;
        for (int c = 0; c < 40 && rx.size() < 5; c++) begin
            M_TREADY = !(c == 2 || c == 3);
            step();
        end
        M_TREADY = 1'b1;
        chk("bp_holds", nh, 2);
        for (int b = 0; b < 5; b++) exq.push_back(mk(1, 0, b, 5));
        chk_rx("bp_rx");
        chk("bp_cnt1", FRAME_CNT1, 1);

        // mid-frame stall keeps the grant, then async reset
        push(0, 0, 4);
        push(1, 0, 2);
        drive();
        for (int k = 0; k < 20 && q0.size() > 2; k++) step();
        chk("stall_popped", q0.size(), 2);
        en0 = 1'b0;
        M_TREADY = 1'b0;
        drive();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_grant", GRANT, 2'b01);
            chk("stall_s1_tready", S1_TREADY, 0);
        end
        resetn = 1'b0;
        #1;
        chk("mrst_mvalid", M_TVALID, 0);
        chk("mrst_cnt", {FRAME_CNT0, FRAME_CNT1}, 0);
        chk("mrst_grant", GRANT, 0);
        q0.delete();
        q1.delete();
        en0 = 1'b1;
        M_TREADY = 1'b1;
        drive();
        prev_hold = 1'b0;
        step();
        resetn = 1'b1;
        step();
        chk("mrst_idle", {GRANT, M_TVALID}, 0);

        // frame counter wrap
        rx.delete();
        force dut.cnt0 = 32'hFFFF_FFFF;
        #1;
        release dut.cnt0;
        push(0, 7, 1);
        drive();
        step();
        chk("wrap_grant", GRANT, 2'b01);
        step();
        chk("wrap_cnt0", FRAME_CNT0, 0);
        chk("wrap_grant_end", GRANT, 0);
        step();
        exq.delete();
        exq.push_back(mk(0, 7, 0, 1));
        chk_rx("wrap_rx");

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
